// File: rtl/ysyx_22041412_booth_mul_seq.sv
// Iterative radix-4 Booth multiplier for RV64M MUL/MULH/MULHSU/MULHU: one Booth step per cycle.
// Optional early exit when the remaining multiplier bits are all-zero/all-one:
// YSYX_22041412_MUL_EARLY_EXIT_EN.
module ysyx_22041412_booth_mul_seq #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned STEPS = 33
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  localparam int unsigned AccW = 2 * XLEN + 4;
  localparam int unsigned YW   = XLEN + 3;
  localparam int unsigned CntW = $clog2(STEPS + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [AccW-1:0]   x_q;
  logic [YW-1:0]     y_q;
  logic [AccW-1:0]   acc_q;
  logic [CntW-1:0]   cnt_q;
  logic [XLEN-1:0]   result_hi_q;
  logic [XLEN-1:0]   result_lo_q;

  logic              a_sgn;
  logic              b_sgn;
  logic [AccW-1:0]   x_ext;
  logic [YW-1:0]     y_ext;
  logic [2:0]        triplet;
  logic              sel_zero;
  logic              sel_two;
  logic              sel_neg;
  logic [AccW-1:0]   mag;
  logic [AccW-1:0]   pp;
  logic [AccW-1:0]   acc_sum;
  logic              last_step;

  // Encoding 01 (unsigned a, signed b) is not an RV64M op and is handled as fully unsigned.
  assign a_sgn = mul_signed[1];
  assign b_sgn = mul_signed[1] & mul_signed[0];
  assign x_ext = {{(AccW - XLEN){a_sgn & a[XLEN-1]}}, a};
  assign y_ext = {{2{b_sgn & b[XLEN-1]}}, b, 1'b0};

  always_comb begin
    triplet  = y_q[2:0];
    sel_zero = (triplet == 3'b000) || (triplet == 3'b111);
    sel_two  = (triplet == 3'b011) || (triplet == 3'b100);
    sel_neg  = triplet[2];
    mag      = sel_two ? {x_q[AccW-2:0], 1'b0} : x_q;
    if (sel_zero) begin
      pp = '0;
    end else if (sel_neg) begin
      pp = '0 - mag;
    end else begin
      pp = mag;
    end
    acc_sum = acc_q + pp;
`ifdef YSYX_22041412_MUL_EARLY_EXIT_EN
    // Remaining multiplier is pure sign extension: every further step adds zero.
    last_step = (cnt_q == CntW'(STEPS - 1)) || (y_q == '0) || (&y_q);
`else
    last_step = (cnt_q == CntW'(STEPS - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_hi_q <= '0;
      result_lo_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!flush && in_valid) begin
            x_q     <= x_ext;
            y_q     <= y_ext;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (flush) begin
            acc_q   <= '0;
            state_q <= StIdle;
          end else begin
            acc_q <= acc_sum;
            x_q   <= x_q << 2;
            y_q   <= {{2{y_q[YW-1]}}, y_q[YW-1:2]};
            cnt_q <= cnt_q + CntW'(1);
            if (last_step) begin
              result_hi_q <= acc_sum[2*XLEN-1:XLEN];
              result_lo_q <= acc_sum[XLEN-1:0];
              state_q     <= StDone;
            end
          end
        end
        StDone: begin
          if (flush) begin
            acc_q   <= '0;
            state_q <= StIdle;
          end else if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result_hi = result_hi_q;
  assign result_lo = result_lo_q;

endmodule
